// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one partial product or quotient bit per cycle, n cycles busy, done pulse in cycle n+1.
// Backpressure: start is only sampled in IDLE or DONE; requests while busy are dropped, not queued.
module muldiv_unit #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   MDControl,
   input  logic [n-1:0] SrcA,
   input  logic [n-1:0] SrcB,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] MDResult,
   output logic         Zero,
   output logic         Sign
);

   localparam int CW = $clog2(n);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    op_q, op_d;
   logic [n-1:0]  opd_q, opd_d;
   logic [n-1:0]  hi_q, hi_d;
   logic [n-1:0]  lo_q, lo_d;
   logic [n-1:0]  res_q, res_d;
   logic          neg_q, neg_d;
   logic          rneg_q, rneg_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          a_sgn, b_sgn, a_neg, b_neg;
   logic [n-1:0]  a_mag, b_mag;
   logic [n:0]    mul_sum;
   logic [n:0]    div_sh;
   logic [n-1:0]  div_diff;
   logic          div_ge;
   logic [n-1:0]  step_hi, step_lo;
   logic [2*n-1:0] prod, prod_c;
   logic [n-1:0]  quo_c, rem_c, fin;

   assign a_sgn = (MDControl == 3'b001) || (MDControl == 3'b010) ||
                  (MDControl == 3'b100) || (MDControl == 3'b110);
   assign b_sgn = (MDControl == 3'b001) || (MDControl == 3'b100) || (MDControl == 3'b110);
   assign a_neg = a_sgn & SrcA[n-1];
   assign b_neg = b_sgn & SrcB[n-1];
   assign a_mag = a_neg ? -SrcA : SrcA;
   assign b_mag = b_neg ? -SrcB : SrcB;

   // hi:lo is the shared datapath: product accumulator/multiplier, or remainder/quotient
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(n+1){1'b0}});
   assign div_sh   = {hi_q, lo_q[n-1]};
   assign div_ge   = (div_sh >= {1'b0, opd_q});
   assign div_diff = div_sh[n-1:0] - opd_q;

   assign step_hi = op_q[2] ? (div_ge ? div_diff : div_sh[n-1:0]) : mul_sum[n:1];
   assign step_lo = op_q[2] ? {lo_q[n-2:0], div_ge} : {mul_sum[0], lo_q[n-1:1]};

   assign prod   = {step_hi, step_lo};
   assign prod_c = neg_q ? -prod : prod;
   assign quo_c  = neg_q ? -step_lo : step_lo;
   assign rem_c  = rneg_q ? -step_hi : step_hi;

   always_comb begin
      fin = prod_c[n-1:0];
      case (op_q)
         3'b000:                 fin = prod_c[n-1:0];
         3'b001, 3'b010, 3'b011: fin = prod_c[2*n-1:n];
         3'b100, 3'b101:         fin = quo_c;
         default:                fin = rem_c;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opd_d   = opd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      res_d   = res_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         CALC: begin
            hi_d   = step_hi;
            lo_d   = step_lo;
            cnt_d  = cnt_q + CW'(1);
            busy_d = 1'b1;
            if (cnt_q == CW'(n-1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               res_d   = fin;
            end
         end
         default: begin
            if (start) begin
               state_d = CALC;
               busy_d  = 1'b1;
               cnt_d   = '0;
               op_d    = MDControl;
               hi_d    = '0;
               rneg_d  = a_neg;
               // divide by zero keeps the all-ones quotient unsigned
               neg_d   = MDControl[2] ? ((a_neg ^ b_neg) && (SrcB != '0)) : (a_neg ^ b_neg);
               opd_d   = MDControl[2] ? b_mag : a_mag;
               lo_d    = MDControl[2] ? a_mag : b_mag;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         opd_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opd_q   <= opd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign MDResult = res_q;
   assign Zero     = (MDResult == '0);
   assign Sign     = MDResult[n-1];

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (n=32): directed vector table, back-to-back, reset abort and random ops.
module tb_muldiv_unit;

   localparam int N   = 32;
   localparam int LAT = N + 1;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          k;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  MDControl = 3'd0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        busy, done, Zero, Sign;
   logic [31:0] MDResult;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          busy_run = 0;
   int          done_prev = 0;
   int          done_last = 0;
   logic [31:0] last_res = '0;
   exp_t        sb_q[$];
   vec_t        vt[18];

   muldiv_unit #(.n(N)) dut (
      .clk(clk), .rst(rst), .start(start), .MDControl(MDControl),
      .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
      .MDResult(MDResult), .Zero(Zero), .Sign(Sign)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb, ub;
      int          ia, ib;
      logic        ovf;
      ia  = a;
      ib  = b;
      sa  = ia;
      sb  = ib;
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      ref_model = '0;
      case (op)
         3'd0: begin p = sa * sb; ref_model = p[31:0]; end
         3'd1: begin p = sa * sb; ref_model = p[63:32]; end
         3'd2: begin p = sa * ub; ref_model = p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; ref_model = p[63:32]; end
         3'd4: ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: ref_model = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
         default: ref_model = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: pick_val = 32'd0;
         1: pick_val = 32'd1;
         2: pick_val = 32'hFFFF_FFFF;
         3: pick_val = 32'h8000_0000;
         4: pick_val = 32'h7FFF_FFFF;
         default: pick_val = $urandom;
      endcase
   endfunction

   // Scoreboard side: every done pops one expectation and checks value, flags and timing
   initial forever begin
      @(negedge clk);
      if (rst) begin
         busy_run = 0;
         last_res = '0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 64'(MDResult), 64'hDEAD_0000_0000_0000);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("result", 64'(MDResult), 64'(e.res));
               check("zero_flag", 64'(Zero), 64'(e.res == 32'd0));
               check("sign_flag", 64'(Sign), 64'(e.res[31]));
               check("latency", 64'(cyc - e.k), 64'(LAT));
               check("busy_cycles", 64'(busy_run), 64'(N));
               check("done_busy_overlap", 64'(busy), 64'd0);
            end
            done_prev = done_last;
            done_last = cyc;
            busy_run  = 0;
         end else begin
            check("result_hold", 64'(MDResult), 64'(last_res));
         end
         last_res = MDResult;
      end
   end

   task automatic wait_ready();
      int t;
      t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (busy) check("ready_timeout", 64'(busy), 64'd0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
      wait_ready();
      start     = 1'b1;
      MDControl = op;
      SrcA      = a;
      SrcB      = b;
      sb_q.push_back('{exp_res, cyc});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int k1;
      vt[0]  = '{3'd0, 32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vt[1]  = '{3'd1, 32'h8000_0000,   32'h8000_0000, 32'h4000_0000};
      vt[2]  = '{3'd2, 32'h8000_0000,   32'h8000_0000, 32'hC000_0000};
      vt[3]  = '{3'd3, 32'h8000_0000,   32'h8000_0000, 32'h4000_0000};
      vt[4]  = '{3'd4, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD};
      vt[5]  = '{3'd6, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF};
      vt[6]  = '{3'd5, 32'hFFFF_FFFF,   32'd0,         32'hFFFF_FFFF};
      vt[7]  = '{3'd7, 32'hFFFF_FFFF,   32'd0,         32'hFFFF_FFFF};
      vt[8]  = '{3'd4, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000};
      vt[9]  = '{3'd6, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0};
      vt[10] = '{3'd0, 32'h8000_0000,   32'h8000_0000, 32'd0};
      vt[11] = '{3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vt[12] = '{3'd4, 32'd7,           32'hFFFF_FFFE, 32'hFFFF_FFFD};
      vt[13] = '{3'd6, 32'd7,           32'hFFFF_FFFE, 32'd1};
      vt[14] = '{3'd6, 32'hFFFF_FFFB,   32'd0,         32'hFFFF_FFFB};
      vt[15] = '{3'd5, 32'd100,         32'd7,         32'd14};
      vt[16] = '{3'd1, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'd0};
      vt[17] = '{3'd7, 32'd100,         32'd7,         32'd2};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(MDResult), 64'd0);
      check("rst_zero", 64'(Zero), 64'd1);
      check("rst_sign", 64'(Sign), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, issued back to back
      for (int i = 0; i < 18; i++) issue(vt[i].op, vt[i].a, vt[i].b, vt[i].res);
      drain();

      // Start held high, second op queued into the DONE cycle, inputs churned during CALC
      @(negedge clk);
      k1        = cyc;
      start     = 1'b1;
      MDControl = 3'd0;
      SrcA      = 32'd12345;
      SrcB      = 32'd678;
      sb_q.push_back('{32'd8369910, k1});
      for (int i = 1; i <= N; i++) begin
         @(negedge clk);
         SrcA      = $urandom;
         SrcB      = $urandom;
         MDControl = 3'($urandom_range(0, 7));
         start     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start     = 1'b1;
      MDControl = 3'd5;
      SrcA      = 32'd1000;
      SrcB      = 32'd33;
      sb_q.push_back('{32'd30, cyc});
      @(negedge clk);
      start = 1'b0;
      drain();
      check("b2b_spacing", 64'(done_last - done_prev), 64'(LAT));

      // Reset during CALC cycle 10 of a divide
      issue(3'd4, 32'hFFFF_FF00, 32'd7, 32'd0);
      k1 = sb_q[0].k;
      while (cyc < k1 + 10) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      sb_q.delete();
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(MDResult), 64'd0);
      check("abort_zero", 64'(Zero), 64'd1);
      check("abort_sign", 64'(Sign), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(3'd0, 32'd3, 32'd5, 32'd15);
      drain();

      // Random operations against the reference model
      for (int i = 0; i < 1500; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = pick_val();
         b  = pick_val();
         issue(op, a, b, ref_model(op, a, b));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
